seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/seg7_scan_driver.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, scan-state type and timing helper for the quad 7-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    function automatic int digit_cycles(input int clk_hz, input int frame_hz);
        return clk_hz / (frame_hz * 4);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment code; non-BCD values show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Nibble lookup
    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a quad common-anode 7-segment display with per-slot dead time.
// Optional leading-zero blanking on digits 3..1 is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ       = 27_000_000,
    parameter int FRAME_HZ     = 250,
    parameter int BLANK_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_tick
);

    localparam int DIGIT_CYCLES = digit_cycles(CLK_HZ, FRAME_HZ);
    localparam int CNT_W        = $clog2(DIGIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    generate
        if (BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_blank
            $error("BLANK_CYCLES must be smaller than DIGIT_CYCLES");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [1:0]       digit_r, digit_next_s;
    scan_state_t      state_r, state_next_s;
    logic             active_r;
    logic             start_s;
    logic [15:0]      shadow_bcd_r;
    logic [3:0]       shadow_dp_r;
    logic [3:0]       cur_nibble_s;
    logic [6:0]       dec_seg_s;
    logic [3:0]       lead_blank_s;
    logic [6:0]       seg_next_s;
    logic             dp_next_s;
    logic [3:0]       an_next_s;

    // Slot counter, digit index and scan state advance; a frame starts on entry to digit 0 slot 0
    always_comb begin
        start_s      = 1'b0;
        cnt_next_s   = cnt_r;
        digit_next_s = digit_r;
        if (!enable) begin
            cnt_next_s   = '0;
            digit_next_s = 2'd0;
        end else if (!active_r) begin
            start_s      = 1'b1;
            cnt_next_s   = '0;
            digit_next_s = 2'd0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_next_s   = '0;
            digit_next_s = digit_r + 2'd1;
            start_s      = (digit_r == 2'd3);
        end else begin
            cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        state_next_s = (cnt_next_s < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
    end

    assign cur_nibble_s = shadow_bcd_r[{digit_r, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (cur_nibble_s),
        .seg    (dec_seg_s)
    );

    // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows
    always_comb begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lead_blank_s    = 4'b0000;
        lead_blank_s[3] = (shadow_bcd_r[15:12] == 4'd0);
        lead_blank_s[2] = lead_blank_s[3] && (shadow_bcd_r[11:8] == 4'd0);
        lead_blank_s[1] = lead_blank_s[2] && (shadow_bcd_r[7:4] == 4'd0);
`else
        lead_blank_s    = 4'b0000;
`endif
    end

    // Next output values; dark whenever not scanning or inside the dead-time gap
    always_comb begin
        seg_next_s = SEG_BLANK;
        dp_next_s  = 1'b1;
        an_next_s  = 4'hF;
        if (enable && active_r && (state_r == ST_DRIVE)) begin
            seg_next_s = lead_blank_s[digit_r] ? SEG_BLANK : dec_seg_s;
            dp_next_s  = ~shadow_dp_r[digit_r];
            case (digit_r)
                2'd0:    an_next_s = 4'b1110;
                2'd1:    an_next_s = 4'b1101;
                2'd2:    an_next_s = 4'b1011;
                2'd3:    an_next_s = 4'b0111;
                default: an_next_s = 4'hF;
            endcase
        end else begin
            seg_next_s = SEG_BLANK;
            dp_next_s  = 1'b1;
            an_next_s  = 4'hF;
        end
    end

    // State, shadow and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= '0;
            digit_r      <= 2'd0;
            state_r      <= ST_BLANK;
            active_r     <= 1'b0;
            shadow_bcd_r <= 16'h0000;
            shadow_dp_r  <= 4'h0;
            seg_n        <= SEG_BLANK;
            dp_n         <= 1'b1;
            an_n         <= 4'hF;
            frame_tick   <= 1'b0;
        end else begin
            cnt_r      <= cnt_next_s;
            digit_r    <= digit_next_s;
            state_r    <= state_next_s;
            active_r   <= enable;
            frame_tick <= start_s;
            seg_n      <= seg_next_s;
            dp_n       <= dp_next_s;
            an_n       <= an_next_s;
            if (start_s) begin
                shadow_bcd_r <= bcd_in;
                shadow_dp_r  <= dp_in;
            end else begin
                shadow_bcd_r <= shadow_bcd_r;
                shadow_dp_r  <= shadow_dp_r;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a timeline model of the display.
// The model tracks cycles since the scan started and the value latched at every frame start.
module tb_seg7_scan_driver;

    localparam int FRAME = 80;
    localparam int SLOT  = 20;
    localparam int BLANK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_tick;

    int pass_cnt  = 0;
    int check_cnt = 0;

    bit          m_running = 1'b0;
    int          m_t       = 0;
    logic [15:0] m_bcd_q[$];
    logic [3:0]  m_dp_q[$];

    seg7_scan_driver #(
        .CLK_HZ       (800),
        .FRAME_HZ     (10),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", tag, got, exp, m_t, $time);
    endtask

    function automatic logic [6:0] code_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare all outputs
    task automatic step();
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [3:0]  e_an;
        logic        e_tick;
        logic [15:0] val;
        int pos, f, w, d, s;
        @(posedge clk);
        if (rst) begin
            m_running = 1'b0;
            m_t = 0;
        end else if (!enable) begin
            m_running = 1'b0;
        end else if (!m_running) begin
            m_running = 1'b1;
            m_t = 0;
            m_bcd_q.delete();
            m_dp_q.delete();
            m_bcd_q.push_back(bcd_in);
            m_dp_q.push_back(dp_in);
        end else begin
            m_t++;
            if (m_t % FRAME == 0) begin
                m_bcd_q.push_back(bcd_in);
                m_dp_q.push_back(dp_in);
            end
        end
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_tick = 1'b0;
        if (m_running) begin
            e_tick = (m_t % FRAME == 0);
            if (m_t >= 1) begin
                pos = m_t - 1;
                f = pos / FRAME;
                w = pos % FRAME;
                d = w / SLOT;
                s = w % SLOT;
                if (s >= BLANK) begin
                    val  = m_bcd_q[f];
                    e_an = ~(4'b0001 << d);
                    e_dp = ~m_dp_q[f][d];
                    e_seg = code_of(4'((val >> (4 * d)) & 16'h000F));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                    if (d >= 1 && (val >> (4 * d)) == 16'h0000) e_seg = 7'h7F;
`endif
                end
            end
        end
        #1;
        check("seg_n", {9'h000, seg_n}, {9'h000, e_seg});
        check("dp_n", {15'h0000, dp_n}, {15'h0000, e_dp});
        check("an_n", {12'h000, an_n}, {12'h000, e_an});
        check("frame_tick", {15'h0000, frame_tick}, {15'h0000, e_tick});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0100;
        run(3);
        check("reset_an", {12'h000, an_n}, 16'h000F);
        check("reset_seg", {9'h000, seg_n}, 16'h007F);
        check("reset_tick", {15'h0000, frame_tick}, 16'h0000);

        // Release: first edge ticks; t=45 is the first lit cycle of digit 2
        rst = 1'b0;
        step();
        check("first_tick", {15'h0000, frame_tick}, 16'h0001);
        run(45);
        check("d2_an", {12'h000, an_n}, 16'h000B);
        check("d2_seg", {9'h000, seg_n}, 16'h0024);
        check("d2_dp", {15'h0000, dp_n}, 16'h0000);

        // Change mid-frame (t=110); the next frame (t=160) latches 9876
        run(65);
        bcd_in = 16'h9876; dp_in = 4'b0000;
        run(55);
        check("latch_d0_seg", {9'h000, seg_n}, 16'h0002);
        check("latch_d0_an", {12'h000, an_n}, 16'h000E);

        // Invalid nibble and leading zeros, latched at t=240
        bcd_in = 16'h00A0;
        run(100);
        check("dash_d1", {9'h000, seg_n}, 16'h003F);
        run(40);
        check("d3_an", {12'h000, an_n}, 16'h0007);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check("d3_lead", {9'h000, seg_n}, 16'h007F);
`else
        check("d3_lead", {9'h000, seg_n}, 16'h0040);
`endif

        // Enable drop during digit 2 drive (t=365)
        run(60);
        enable = 1'b0;
        run(10);
        check("disabled_an", {12'h000, an_n}, 16'h000F);
        enable = 1'b1;
        step();
        check("reenable_tick", {15'h0000, frame_tick}, 16'h0001);

        // Reset pulse during digit 3 drive, then a fresh frame
        run(69);
        bcd_in = 16'h0507; dp_in = 4'b1001;
        rst = 1'b1;
        step();
        check("midrst_an", {12'h000, an_n}, 16'h000F);
        rst = 1'b0;
        run(100);

        // Randomized traffic
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                bcd_in = 16'($urandom) >> (4 * $urandom_range(0, 3));
                dp_in  = 4'($urandom);
            end
            enable = ($urandom_range(0, 79) != 0);
            rst    = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; enable = 1'b1;
        run(FRAME);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
